mem_trace_capture: RTL and testbench

MEM_TRACE_CAPTURE -- requirements
Module: mem_trace_capture

---
 rtl/mem_trace_capture_if.sv | 27 ++
 rtl/mem_trace_capture.sv | 82 ++++++++
 tb/tb_mem_trace_capture.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/mem_trace_capture_if.sv
// Trace capture bus: datapath write strobes in, buffered trace records and status out.
interface mem_trace_capture_if #(
  parameter int unsigned DEPTH = 8
);
  logic                     capture_en;
  logic                     MemWrite;
  logic [31:0]              PC_out;
  logic [31:0]              mem_data;
  logic                     rec_valid;
  logic                     rec_ready;
  logic [31:0]              rec_pc;
  logic [31:0]              rec_data;
  logic [$clog2(DEPTH):0]   fifo_count;
  logic                     overflow;
  logic [15:0]              drop_count;
  logic                     halt_req;

  modport master (
    output capture_en, MemWrite, PC_out, mem_data, rec_ready,
    input  rec_valid, rec_pc, rec_data, fifo_count, overflow, drop_count, halt_req
  );

  modport slave (
    input  capture_en, MemWrite, PC_out, mem_data, rec_ready,
    output rec_valid, rec_pc, rec_data, fifo_count, overflow, drop_count, halt_req
  );
endinterface

// File: rtl/mem_trace_capture.sv
// Captures {PC, data} of memory writes into a FIFO until the PC passes PC_LIMIT,
// then drains the FIFO and raises halt_req.
module mem_trace_capture #(
  parameter int unsigned DEPTH    = 8,
  parameter logic [31:0] PC_LIMIT = 32'h84
) (
  input logic                clk,
  input logic                reset,
  mem_trace_capture_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {StRun, StDrain, StDone} state_e;

  state_e          state_q, state_d;
  logic [63:0]     mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic            overflow_q;
  logic [15:0]     drop_count_q;
  logic            over_limit, capture, pop, full, push, drop;

  always_comb begin
    over_limit = bus.PC_out > PC_LIMIT;
    capture    = (state_q == StRun) && bus.capture_en && bus.MemWrite && !over_limit;
    pop        = (count_q != '0) && bus.rec_ready;
    full       = (count_q == CW'(DEPTH));
    // A full FIFO still accepts a record when the head leaves in the same cycle.
    push       = capture && (!full || pop);
    drop       = capture && full && !pop;
    count_d    = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:   if (over_limit) state_d = StDrain;
      // No pushes in drain, so count_d is zero exactly when empty or emptied by this pop.
      StDrain: if (count_d == '0) state_d = StDone;
      StDone:  state_d = StDone;
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StRun;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_count_q != 16'hFFFF) drop_count_q <= drop_count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset && push) mem_q[wr_ptr_q] <= {bus.PC_out, bus.mem_data};
  end

  assign bus.rec_valid  = (count_q != '0);
  assign bus.rec_pc     = bus.rec_valid ? mem_q[rd_ptr_q][63:32] : 32'h0;
  assign bus.rec_data   = bus.rec_valid ? mem_q[rd_ptr_q][31:0]  : 32'h0;
  assign bus.fifo_count = count_q;
  assign bus.overflow   = overflow_q;
  assign bus.drop_count = drop_count_q;
  assign bus.halt_req   = (state_q == StDone);
endmodule

// File: tb/tb_mem_trace_capture.sv
// Randomized scoreboard bench for mem_trace_capture against a queue-based reference model.
module tb_mem_trace_capture;
  localparam int unsigned DEPTH = 8;
  localparam logic [31:0] LIMIT = 32'h84;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  mem_trace_capture_if #(.DEPTH(DEPTH)) bus ();

  mem_trace_capture #(.DEPTH(DEPTH), .PC_LIMIT(LIMIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: expected records in write order plus status.
  typedef enum {MRun, MDrain, MDone} mstate_e;
  logic [63:0] exp_q [$];
  int          occ   = 0;
  bit          ovf   = 0;
  int          drops = 0;
  mstate_e     mst   = MRun;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Drive one cycle, advance the model over the coming edge, then check status.
  task automatic step(input bit rst_n, input bit ce, input bit mw, input logic [31:0] pc,
                      input logic [31:0] data, input bit rdy);
    bit pop;
    bit cap;
    reset          = rst_n;
    bus.capture_en = ce;
    bus.MemWrite   = mw;
    bus.PC_out     = pc;
    bus.mem_data   = data;
    bus.rec_ready  = rdy;
    if (!rst_n) begin
      occ = 0; ovf = 0; drops = 0; mst = MRun;
      exp_q.delete();
    end else begin
      pop = rdy && (occ > 0);
      cap = (mst == MRun) && ce && mw && (pc <= LIMIT);
      if (cap) begin
        if (occ < DEPTH || pop) begin
          exp_q.push_back({pc, data});
          occ++;
        end else begin
          ovf = 1;
          if (drops < 65535) drops++;
        end
      end
      if (pop) occ--;
      if (mst == MRun && pc > LIMIT) mst = MDrain;
      else if (mst == MDrain && occ == 0) mst = MDone;
    end
    @(posedge clk);
    #1;
    chk("fifo_count", 64'(bus.fifo_count), 64'(occ));
    chk("rec_valid", 64'(bus.rec_valid), 64'(occ > 0));
    chk("overflow", 64'(bus.overflow), 64'(ovf));
    chk("drop_count", 64'(bus.drop_count), 64'(drops));
    chk("halt_req", 64'(bus.halt_req), 64'(mst == MDone));
    if (occ > 0 && exp_q.size() > 0) chk("head", {bus.rec_pc, bus.rec_data}, exp_q[0]);
    else chk("idle_rec", {bus.rec_pc, bus.rec_data}, 64'h0);
  endtask

  task automatic drain(input logic [31:0] pc);
    for (int i = 0; i < 2 * DEPTH + 4; i++) begin
      if (occ == 0) break;
      step(1, 0, 0, pc, 32'h0, 1);
    end
    chk("drained", 64'(occ), 64'h0);
  endtask

  // Monitor: every handshake pops the scoreboard; held records must not change.
  bit          hold = 0;
  logic [63:0] held;
  always @(negedge clk) begin
    if (reset) begin
      if (hold) begin
        chk("stable_valid", 64'(bus.rec_valid), 64'h1);
        chk("stable_rec", {bus.rec_pc, bus.rec_data}, held);
      end
      if (bus.rec_valid && bus.rec_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_record: got %0h expected none", {bus.rec_pc, bus.rec_data});
        end else begin
          chk("record", {bus.rec_pc, bus.rec_data}, exp_q.pop_front());
        end
      end
      hold = bus.rec_valid && !bus.rec_ready;
      held = {bus.rec_pc, bus.rec_data};
    end else begin
      hold = 0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] pc;
    logic [31:0] data;
    // Reset state
    step(0, 0, 0, 32'h0, 32'h0, 0);
    step(0, 0, 0, 32'h0, 32'h0, 0);

    // Single write, then drain
    step(1, 1, 1, 32'h10, 32'hDEADBEEF, 0);
    step(1, 0, 0, 32'h10, 32'h0, 0);
    drain(32'h10);

    // Overflow: 10 writes into an 8-deep FIFO with no reads
    for (int i = 0; i < 10; i++) step(1, 1, 1, 32'(i * 4), 32'hA000_0000 + 32'(i), 0);
    // Full FIFO with a simultaneous pop accepts the new record
    step(1, 1, 1, 32'h40, 32'hBEEF_0040, 1);
    drain(32'h10);

    // Mid-operation reset with records queued and overflow set
    for (int i = 0; i < 13; i++) step(1, 1, 1, 32'(i * 4), 32'hC000_0000 + 32'(i), 0);
    for (int i = 0; i < 8; i++)  step(1, 0, 0, 32'h10, 32'h0, i < 3);
    step(0, 1, 1, 32'h10, 32'h1, 1);

    // Wrap-around: 20 writes with continuous reads
    for (int i = 0; i < 20; i++) step(1, 1, 1, 32'(i * 4), 32'hD000_0000 + 32'(i), 1);
    drain(32'h10);

    // Randomized traffic below the limit, PC_LIMIT itself included
    for (int i = 0; i < 400; i++) begin
      pc   = 32'($urandom_range(0, 32'h84));
      data = 32'($urandom);
      step(1, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, pc, data,
           $urandom_range(0, 2) == 0);
    end
    drain(32'h10);

    // Limit: three records, trigger at 0x88 with a write, PC drops back in drain
    step(0, 0, 0, 32'h0, 32'h0, 0);
    step(1, 1, 1, 32'h80, 32'h1111, 0);
    step(1, 1, 1, 32'h84, 32'h2222, 0);
    step(1, 1, 1, 32'h10, 32'h3333, 0);
    step(1, 1, 1, 32'h88, 32'h4444, 0);
    step(1, 1, 1, 32'h20, 32'h5555, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 1, 32'h20, 32'h6666, 1);
    for (int i = 0; i < 4; i++) step(1, 1, 1, 32'h10, 32'h7777, 1);

    // Reset out of DONE returns to capture
    step(0, 0, 0, 32'h0, 32'h0, 0);
    step(1, 1, 1, 32'h30, 32'h8888, 0);
    drain(32'h10);

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
